// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcodes, flag bit positions and arbiter FSM states for the ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_CMP = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;

    // Bit positions within the 5-bit {C,L,F,Z,N} flag vector
    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_arbiter_rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Purpose  : Combinational 2-way round-robin selector; ties go to the port
//            that was not granted last.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant,
    output logic       any
);

    assign any   = |valid;
    assign grant = (valid == 2'b11) ? ~last : valid[1];

endmodule : rr_pick2

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one ALU between two valid/ready requesters, one op at a time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [OPW-1:0]   req_op_0,
    output logic             resp_valid_0,
    input  logic             resp_ready_0,

    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [OPW-1:0]   req_op_1,
    output logic             resp_valid_1,
    input  logic             resp_ready_1,

    output logic [WIDTH-1:0] resp_result,
    output logic [4:0]       resp_flags,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_ctl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_C,
    input  logic             alu_L,
    input  logic             alu_F,
    input  logic             alu_Z,
    input  logic             alu_N,

    output logic             busy
);

    arb_state_t       r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_ctl;
    logic [WIDTH-1:0] r_resp_result;
    logic [4:0]       r_resp_flags;

    logic             w_pick;
    logic             w_any;
    logic             w_idle;
    logic             w_resp_ready;

    rr_pick2 u_pick (
        .valid ({req_valid_1, req_valid_0}),
        .last  (r_last_grant),
        .grant (w_pick),
        .any   (w_any)
    );

    assign w_idle       = (r_state == ST_IDLE);
    assign w_resp_ready = r_owner ? resp_ready_1 : resp_ready_0;

    assign req_ready_0  = w_idle && w_any && !w_pick;
    assign req_ready_1  = w_idle && w_any &&  w_pick;
    assign resp_valid_0 = (r_state == ST_RESP) && !r_owner;
    assign resp_valid_1 = (r_state == ST_RESP) &&  r_owner;
    assign busy         = !w_idle;

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctl     = r_alu_ctl;
    assign resp_result = r_resp_result;
    assign resp_flags  = r_resp_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_ctl     <= '0;
            r_resp_result <= '0;
            r_resp_flags  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_alu_a      <= w_pick ? req_a_1  : req_a_0;
                        r_alu_b      <= w_pick ? req_b_1  : req_b_0;
                        r_alu_ctl    <= w_pick ? req_op_1 : req_op_0;
                        r_owner      <= w_pick;
                        r_last_grant <= w_pick;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU inputs have been stable for a full cycle; sample its outputs
                    r_resp_result       <= alu_result;
                    r_resp_flags[FLG_C] <= alu_C;
                    r_resp_flags[FLG_L] <= alu_L;
                    r_resp_flags[FLG_F] <= alu_F;
                    r_resp_flags[FLG_Z] <= alu_Z;
                    r_resp_flags[FLG_N] <= alu_N;
                    r_state             <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : alu_arbiter

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv [2];
    logic        rr [2];
    logic [15:0] ra [2];
    logic [15:0] rb [2];
    logic [3:0]  rop [2];
    logic [1:0]  rdy;
    logic [1:0]  rspv;
    logic [15:0] resp_result, alu_a, alu_b, alu_result;
    logic [4:0]  resp_flags;
    logic [3:0]  alu_ctl;
    logic        busy;
    logic [20:0] alu_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {C,L,F,Z,N,result}
    function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        logic [16:0] s;
        logic [15:0] r;
        logic c, l, f, n;
        c = 1'b0; l = 1'b0; f = 1'b0; n = 1'b0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                f = (a[15] == b[15]) && (r[15] != a[15]);
            end
            ALU_SUB, ALU_CMP: begin
                r = a - b;
                c = (a < b);
                f = (a[15] != b[15]) && (r[15] != a[15]);
                if (op == ALU_CMP) begin
                    l = (a < b);
                    n = ($signed(a) < $signed(b));
                end
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            default: r = a;
        endcase
        return {c, l, f, (r == 16'h0000), n, r};
    endfunction

    assign alu_out    = alu_fn(alu_a, alu_b, alu_ctl);
    assign alu_result = alu_out[15:0];

    alu_arbiter #(.WIDTH(16), .OPW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_0  (rv[0]),
        .req_ready_0  (rdy[0]),
        .req_a_0      (ra[0]),
        .req_b_0      (rb[0]),
        .req_op_0     (rop[0]),
        .resp_valid_0 (rspv[0]),
        .resp_ready_0 (rr[0]),
        .req_valid_1  (rv[1]),
        .req_ready_1  (rdy[1]),
        .req_a_1      (ra[1]),
        .req_b_1      (rb[1]),
        .req_op_1     (rop[1]),
        .resp_valid_1 (rspv[1]),
        .resp_ready_1 (rr[1]),
        .resp_result  (resp_result),
        .resp_flags   (resp_flags),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctl      (alu_ctl),
        .alu_result   (alu_result),
        .alu_C        (alu_out[16 + FLG_C]),
        .alu_L        (alu_out[16 + FLG_L]),
        .alu_F        (alu_out[16 + FLG_F]),
        .alu_Z        (alu_out[16 + FLG_Z]),
        .alu_N        (alu_out[16 + FLG_N]),
        .busy         (busy)
    );

    // Arbitration rule and accept-to-response latency, checked every cycle
    int         last_seen = 1;
    int         acc_cyc = -100;
    logic [1:0] prev_rspv = 2'b00;
    logic [1:0] mon_exp;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            last_seen = 1;
            prev_rspv = 2'b00;
        end else begin
            mon_exp = 2'b00;
            if (!busy) begin
                if (rv[0] && rv[1]) mon_exp = (last_seen == 1) ? 2'b01 : 2'b10;
                else                mon_exp = {rv[1], rv[0]};
            end
            tests++;
            if (rdy !== mon_exp) begin
                fails++;
                $display("FAIL grant_pick cyc=%0d req_ready=%b expected %b", cyc, rdy, mon_exp);
            end
            if (rdy == 2'b01) begin last_seen = 0; acc_cyc = cyc; end
            else if (rdy == 2'b10) begin last_seen = 1; acc_cyc = cyc; end
            if (rspv != 2'b00 && prev_rspv == 2'b00) begin
                tests++;
                if (cyc - acc_cyc != 2 || rspv == 2'b11) begin
                    fails++;
                    $display("FAIL resp_latency cyc=%0d resp_valid=%b latency=%0d expected 2",
                             cyc, rspv, cyc - acc_cyc);
                end
            end
            prev_rspv = rspv;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request on port p and consumes its response after 'stall' cycles.
    // Entered and left at posedge+1.
    task automatic do_op(input int p, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input int stall,
                         output logic [15:0] res, output logic [4:0] fl, output bit ok);
        int w;
        ok = 1'b0; res = '0; fl = '0;
        ra[p] = a; rb[p] = b; rop[p] = op; rv[p] = 1'b1;
        w = 0;
        @(negedge clk);
        while (!rdy[p] && w < 40) begin @(negedge clk); w++; end
        if (!rdy[p]) begin rv[p] = 1'b0; @(posedge clk); #1; return; end
        @(posedge clk); #1;
        rv[p] = 1'b0;
        w = 0;
        @(negedge clk);
        while (!rspv[p] && w < 40) begin @(negedge clk); w++; end
        if (!rspv[p]) begin @(posedge clk); #1; return; end
        repeat (stall) @(negedge clk);
        res = resp_result; fl = resp_flags; rr[p] = 1'b1;
        @(posedge clk); #1;
        rr[p] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests++;
            if (rdy !== 2'b00 || rspv !== 2'b00 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_ctrl ready=%b resp_valid=%b busy=%b expected 00 00 0", rdy, rspv, busy);
            end
            tests++;
            if (resp_result !== 16'h0 || resp_flags !== 5'h0) begin
                fails++;
                $display("FAIL reset_resp result=%h flags=%b expected 0000 00000", resp_result, resp_flags);
            end
            tests++;
            if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_ctl !== 4'h0) begin
                fails++;
                $display("FAIL reset_alu a=%h b=%h ctl=%h expected 0", alu_a, alu_b, alu_ctl);
            end
            @(posedge clk); #1;
            reset = 1'b0;
        end
    endtask

    task automatic test_tie();
        logic [15:0] r0a, r0b, r1;
        logic [4:0]  f;
        bit          ok0a, ok0b, ok1;
        int          t0a, t0b, t1;
        fork
            begin
                do_op(0, 16'h0003, 16'h0001, ALU_SUB, 0, r0a, f, ok0a); t0a = cyc;
                do_op(0, 16'h0005, 16'h0006, ALU_ADD, 0, r0b, f, ok0b); t0b = cyc;
            end
            begin
                do_op(1, 16'h0002, 16'h0003, ALU_XOR, 0, r1, f, ok1); t1 = cyc;
            end
        join
        tests++;
        if (!ok0a || r0a !== 16'h0002) begin
            fails++; $display("FAIL tie_port0 ok=%0d result=%h expected 0002", ok0a, r0a);
        end
        tests++;
        if (!ok1 || r1 !== 16'h0001) begin
            fails++; $display("FAIL tie_port1 ok=%0d result=%h expected 0001", ok1, r1);
        end
        tests++;
        if (!ok0b || r0b !== 16'h000B) begin
            fails++; $display("FAIL tie_port0_second ok=%0d result=%h expected 000b", ok0b, r0b);
        end
        tests++;
        if (!(t0a < t1 && t1 < t0b)) begin
            fails++; $display("FAIL tie_order p0=%0d p1=%0d p0b=%0d expected p0<p1<p0b", t0a, t1, t0b);
        end
    endtask

    task automatic test_single_add();
        ra[0] = 16'h0003; rb[0] = 16'h0001; rop[0] = ALU_ADD; rv[0] = 1'b1;
        @(negedge clk);
        tests++;
        if (rdy !== 2'b01) begin fails++; $display("FAIL add_ready cycle0 ready=%b expected 01", rdy); end
        @(posedge clk); #1;
        rv[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (rspv !== 2'b00 || busy !== 1'b1 || alu_a !== 16'h0003 || alu_b !== 16'h0001 || alu_ctl !== ALU_ADD) begin
            fails++;
            $display("FAIL add_exec resp_valid=%b busy=%b a=%h b=%h ctl=%h expected 00 1 0003 0001 0",
                     rspv, busy, alu_a, alu_b, alu_ctl);
        end
        @(negedge clk);
        tests++;
        if (rspv !== 2'b01 || resp_result !== 16'h0004 || resp_flags !== 5'b00000) begin
            fails++;
            $display("FAIL add_resp resp_valid=%b result=%h flags=%b expected 01 0004 00000",
                     rspv, resp_result, resp_flags);
        end
        rr[0] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (rspv !== 2'b00 || busy !== 1'b0 || alu_a !== 16'h0003 || alu_ctl !== ALU_ADD) begin
            fails++;
            $display("FAIL add_after resp_valid=%b busy=%b a=%h ctl=%h expected 00 0 0003 0",
                     rspv, busy, alu_a, alu_ctl);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        ra[0] = 16'h0003; rb[0] = 16'h0003; rop[0] = ALU_CMP; rv[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        ra[1] = 16'h00F0; rb[1] = 16'h000F; rop[1] = ALU_OR; rv[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        held = resp_result;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (rspv !== 2'b01 || resp_flags[FLG_Z] !== 1'b1 || rdy[1] !== 1'b0 ||
                busy !== 1'b1 || resp_result !== held) begin
                fails++;
                $display("FAIL backpressure i=%0d resp_valid=%b Z=%b ready1=%b busy=%b result=%h expected 01 1 0 1 %h",
                         i, rspv, resp_flags[FLG_Z], rdy[1], busy, resp_result, held);
            end
            if (i < 5) @(negedge clk);
        end
        rr[0] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (rdy !== 2'b10) begin fails++; $display("FAIL backpressure_next ready=%b expected 10", rdy); end
        @(posedge clk); #1;
        rv[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (rspv !== 2'b10 || resp_result !== 16'h00FF) begin
            fails++;
            $display("FAIL backpressure_p1 resp_valid=%b result=%h expected 10 00ff", rspv, resp_result);
        end
        rr[1] = 1'b1;
        @(posedge clk); #1;
        rr[1] = 1'b0;
    endtask

    task automatic test_flags();
        logic [15:0] r;
        logic [4:0]  f;
        bit          ok;
        do_op(1, 16'hFFFF, 16'h0001, ALU_ADD, 1, r, f, ok);
        tests++;
        if (!ok || r !== 16'h0000 || f[FLG_C] !== 1'b1 || f[FLG_Z] !== 1'b1) begin
            fails++; $display("FAIL flags_add ok=%0d result=%h flags=%b expected 0000 C=1 Z=1", ok, r, f);
        end
        do_op(0, 16'h0001, 16'h0002, ALU_SUB, 0, r, f, ok);
        tests++;
        if (!ok || r !== 16'hFFFF || f[FLG_C] !== 1'b1) begin
            fails++; $display("FAIL flags_sub ok=%0d result=%h flags=%b expected ffff C=1", ok, r, f);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic [4:0]  f;
        bit          ok;
        ra[0] = 16'h1234; rb[0] = 16'h1111; rop[0] = ALU_ADD; rv[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (rspv !== 2'b00 || rdy !== 2'b00 || busy !== 1'b0 || resp_result !== 16'h0 ||
            resp_flags !== 5'h0 || alu_a !== 16'h0 || alu_b !== 16'h0 || alu_ctl !== 4'h0) begin
            fails++;
            $display("FAIL reset_mid resp_valid=%b ready=%b busy=%b result=%h flags=%b a=%h b=%h ctl=%h expected all 0",
                     rspv, rdy, busy, resp_result, resp_flags, alu_a, alu_b, alu_ctl);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (rspv !== 2'b00) begin fails++; $display("FAIL reset_mid_discard i=%0d resp_valid=%b expected 00", i, rspv); end
        end
        @(posedge clk); #1;
        do_op(0, 16'h0F0F, 16'h00FF, ALU_AND, 0, r, f, ok);
        tests++;
        if (!ok || r !== 16'h000F) begin fails++; $display("FAIL reset_mid_after ok=%0d result=%h expected 000f", ok, r); end
    endtask

    task automatic test_starvation();
        int w;
        ra[0] = 16'h0007; rb[0] = 16'h0001; rop[0] = ALU_ADD; rv[0] = 1'b1; rr[0] = 1'b1;
        w = 0;
        @(negedge clk);
        while (!busy && w < 20) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        ra[1] = 16'hABCD; rb[1] = 16'h0FF0; rop[1] = ALU_AND; rv[1] = 1'b1;
        w = 0;
        @(negedge clk);
        while (!rdy[1] && w < 6) begin @(negedge clk); w++; end
        tests++;
        if (!rdy[1] || w > 3) begin fails++; $display("FAIL starvation accepted=%b wait=%0d expected <=3", rdy[1], w); end
        @(posedge clk); #1;
        rv[1] = 1'b0; rv[0] = 1'b0; rr[0] = 1'b0;
        w = 0;
        @(negedge clk);
        while (!rspv[1] && w < 10) begin @(negedge clk); w++; end
        tests++;
        if (rspv[1] !== 1'b1 || resp_result !== 16'h0BC0) begin
            fails++; $display("FAIL starvation_result resp_valid1=%b result=%h expected 1 0bc0", rspv[1], resp_result);
        end
        rr[1] = 1'b1;
        @(posedge clk); #1;
        rr[1] = 1'b0;
    endtask

    task automatic port_run(input int p, input int n);
        logic [15:0] a, b, res;
        logic [3:0]  op;
        logic [4:0]  fl;
        logic [20:0] exp;
        bit          ok;
        int          gap;
        for (int k = 0; k < n; k++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            op  = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) b = a;
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            do_op(p, a, b, op, $urandom_range(0, 3), res, fl, ok);
            exp = alu_fn(a, b, op);
            tests++;
            if (!ok || res !== exp[15:0] || fl !== exp[20:16]) begin
                fails++;
                $display("FAIL random p%0d k=%0d op=%h a=%h b=%h ok=%0d got %h/%b expected %h/%b",
                         p, k, op, a, b, ok, res, fl, exp[15:0], exp[20:16]);
            end
        end
    endtask

    task automatic test_random();
        fork
            port_run(0, 25);
            port_run(1, 25);
        join
    endtask

    initial begin
        rv[0] = 1'b0; rv[1] = 1'b0; rr[0] = 1'b0; rr[1] = 1'b0;
        ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0; rop[0] = '0; rop[1] = '0;
        test_reset();
        test_tie();
        test_single_add();
        test_backpressure();
        test_flags();
        test_reset_mid();
        test_starvation();
        test_random();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_alu_arbiter

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit ALU between two requesters: port 0 is the processor execute stage and port 1 is the game coprocessor. Each port uses a valid/ready request handshake and a valid/ready response handshake. The block fairly grants one request at a time, drives the ALU operand and control inputs from registered copies, and captures the ALU result and flags. It returns them only to the granted requester. It sits between the requesters and the `alu` instance, and owns all of the ALU's input ports.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width. It must match the ALU.
- `OPW`, 4: ALU control width.

Ports (x = 0, 1 for each requester):
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid_x`  in  1  request x presents an operation
- `req_ready_x`  out  1  request x accepted this cycle
- `req_a_x`, `req_b_x`  in  WIDTH  operands
- `req_op_x`  in  OPW  ALU control code
- `resp_valid_x`  out  1  response for x is available
- `resp_ready_x`  in  1  requester x consumes the response
- `resp_result`  out  WIDTH  captured result, shared by both ports
- `resp_flags`  out  5  captured flags, shared by both ports, ordered {C,L,F,Z,N}
- `alu_a`, `alu_b`  out  WIDTH  ALU operand drive (registered)
- `alu_ctl`  out  OPW  ALU control drive (registered)
- `alu_result`  in  WIDTH  ALU result (combinational from the ALU)
- `alu_C`, `alu_L`, `alu_F`, `alu_Z`, `alu_N`  in  1  ALU flags
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE:
  - Pick the granted port. If only one `req_valid` is high, pick that port. If both are high, pick the port not granted last.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - `req_ready_pick` is high combinationally while in IDLE. The other port's `req_ready` is 0.
  - On the handshake:
    - latch `req_a`, `req_b` and `req_op` into `alu_a`, `alu_b` and `alu_ctl`;
    - record `owner`;
    - set `last_grant` to `owner`;
    - go to EXEC.
- EXEC:
  - The ALU evaluates the registered inputs.
  - At the clock edge, capture `alu_result` into `resp_result` and {`alu_C`,`alu_L`,`alu_F`,`alu_Z`,`alu_N`} into `resp_flags`.
  - Go to RESP.
- RESP:
  - `resp_valid_owner` = 1.
  - When `resp_ready_owner` is high, go to IDLE. `resp_valid` drops on the next cycle.
  - The response is held indefinitely until consumed.
- Opcodes are passed through to the ALU unmodified: 0000 ADD, 0001 SUB, 0010 CMP, 0011 AND, 0100 OR, 0101 XOR. Undefined codes are still executed and returned. CMP returns whatever the ALU drives on `result`.
- Requests arriving in EXEC or RESP see `req_ready` = 0 and must hold `req_valid` and their data stable.
- `alu_a`, `alu_b` and `alu_ctl` keep their last values outside EXEC. This avoids toggling the ALU.

## Timing
- Reset values:
  - state IDLE; `req_ready_x` 0 (because both `req_valid` are low after reset);
  - `resp_valid_x` 0, `resp_result` 0, `resp_flags` 0;
  - `alu_a`, `alu_b`, `alu_ctl` 0; `busy` 0; `last_grant` 1.
- Latency from accept to `resp_valid`:
  - accept edge at cycle N, EXEC in cycle N+1, `resp_valid` high in cycle N+2;
  - earliest next accept is cycle N+3 if the response is consumed in N+2;
  - peak throughput is one operation per 3 cycles.
- Both requests valid in IDLE: exactly one is accepted. The loser is guaranteed acceptance at its next IDLE visit while it stays valid, so it waits at most one operation.
- Reset asserted in EXEC or RESP:
  - next cycle is IDLE with `resp_valid` 0;
  - the in-flight operation is discarded and is never returned.
- `req_valid` and `req_ready` are combinationally dependent only in the direction valid→ready. Requesters must not derive valid from ready.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode constants `ALU_ADD` … `ALU_XOR` (4-bit);
  - the flag bit index constants `FLG_C` = 4 … `FLG_N` = 0;
  - the FSM state enum.
- The grant pick is a natural sub-module, `rr_pick2`: a combinational 2-way round-robin selector taking `valid[1:0]` and `last`, and producing `grant` and `any`.
- The ALU itself is instantiated outside this block, alongside it, in the datapath top.

## Test plan
- Single ADD on port 0: a = 0003, b = 0001, op 0000. Require `req_ready_0` in cycle 0, `resp_valid_0` in cycle 2, `resp_result` = 0004, `resp_flags` = 0.
- Simultaneous requests: port 0 SUB 0003−0001 and port 1 XOR 0002^0003. Require port 0 to be served first (result 0002), then port 1 (result 0001). A second tie then grants port 1 first.
- Back-pressure: hold `resp_ready_0` = 0 for 5 cycles after a CMP with 0003, 0003. Require `resp_valid_0` stable, Z flag = 1, `req_ready_1` = 0 throughout, and `busy` = 1.
- Flags capture:
  - ADD FFFF + 0001 → `resp_result` 0000, C = 1, Z = 1;
  - SUB 0001 − 0002 → C = 1.
- Reset mid-operation: assert `reset` during EXEC. Require `resp_valid` never high for that operation, all outputs at reset values next cycle, and a following request served normally.
- Starvation check: port 0 requests continuously with `resp_ready` tied high while port 1 raises one request. Require port 1 to be accepted within 3 cycles of port 0's current operation completing.
